// File: rtl/adc_spi_reader_if.sv
// Bus bundle between the ADC SPI reader and its surroundings.
// master: the reader (drives SPI pins and sample outputs); slave: the user side.
interface adc_spi_reader_if;
    logic        en;
    logic        miso;
    logic        cs_n;
    logic        sclk;
    logic [15:0] val_out;
    logic        val_valid;
    logic        busy;
    logic        overrun;

    modport master (
        input  en, miso,
        output cs_n, sclk, val_out, val_valid, busy, overrun
    );

    modport slave (
        output en, miso,
        input  cs_n, sclk, val_out, val_valid, busy, overrun
    );
endinterface

// File: rtl/adc_spi_reader.sv
// Periodic SPI master reading a serial ADC, MSB first; outputs a zero-extended
// 16-bit sample with a one-cycle valid strobe.
// Ports: clk, reset (sync, active high), bus (en/miso in; cs_n, sclk, val_out,
// val_valid, busy, overrun out).
module adc_spi_reader #(
    parameter int CLK_DIV       = 4,
    parameter int FRAME_BITS    = 16,
    parameter int LEAD_BITS     = 4,
    parameter int ADC_BITS      = 10,
    parameter int SAMPLE_PERIOD = 200
) (
    input logic              clk,
    input logic              reset,
    adc_spi_reader_if.master bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);
    localparam int TW = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] DATA_LO  = BW'(LEAD_BITS);
    localparam logic [BW-1:0] DATA_HI  = BW'(LEAD_BITS + ADC_BITS - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bit_idx;
    logic [TW-1:0]       timer;
    logic [ADC_BITS-1:0] shreg;
    logic [15:0]         val_q;
    logic                miso_s1;
    logic                miso_s2;
    logic                cs_n_q;
    logic                sclk_q;
    logic                busy_q;
    logic                valid_q;
    logic                ovr_q;
    logic                tick;
    logic                in_data;

    assign tick    = bus.en && (timer == '0);
    assign in_data = (bit_idx >= DATA_LO) && (bit_idx <= DATA_HI);

    assign bus.cs_n      = cs_n_q;
    assign bus.sclk      = sclk_q;
    assign bus.busy      = busy_q;
    assign bus.val_out   = val_q;
    assign bus.val_valid = valid_q;
    assign bus.overrun   = ovr_q;

    // miso is asynchronous to clk
    always_ff @(posedge clk) begin
        if (reset) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= bus.miso;
            miso_s2 <= miso_s1;
        end
    end

    // Free-running period timer; keeps counting during frames so the
    // start-to-start spacing stays fixed.
    always_ff @(posedge clk) begin
        if (reset || !bus.en) begin
            timer <= '0;
        end else if (timer == TMR_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            val_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ovr_q   <= tick && (state != S_IDLE);
            unique case (state)
                S_IDLE: begin
                    if (tick) begin
                        state  <= S_SETUP;
                        cs_n_q <= 1'b0;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        shreg  <= '0;
                    end
                end
                S_SETUP: begin
                    if (cnt == CNT_LAST) begin
                        state   <= S_SHIFT;
                        cnt     <= '0;
                        bit_idx <= '0;
                        sclk_q  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        // sclk_q doubles as the half-period phase flag
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            if (in_data) begin
                                shreg <= {shreg[ADC_BITS-2:0], miso_s2};
                            end
                        end else if (bit_idx == BIT_LAST) begin
                            state <= S_HOLD;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            sclk_q  <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt == CNT_LAST) begin
                        state   <= S_DONE;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        val_q   <= 16'(shreg);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: two instances (sample period 200 and 100) with
// ADC models, checked every cycle against a frame-timing reference model.
module tb_adc_spi_reader;
    localparam int CD = 4;
    localparam int FB = 16;
    localparam int LB = 4;
    localparam int AB = 10;
    localparam int FL = (2 * FB + 2) * CD + 1;

    logic clk = 1'b0;
    logic reset;
    logic en;

    always #5 clk = ~clk;

    adc_spi_reader_if bus0 ();
    adc_spi_reader_if bus1 ();

    assign bus0.en = en;
    assign bus1.en = en;

    adc_spi_reader #(.SAMPLE_PERIOD(200)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    adc_spi_reader #(.SAMPLE_PERIOD(100)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    // ADC models: load a word on cs_n fall, present bit k after sclk fall k
    logic [15:0] next_frame = 16'h0A94;
    logic [15:0] word0 = '0;
    logic [15:0] word1 = '0;
    logic        bit0 = 1'b0;
    logic        bit1 = 1'b0;
    int          k0 = 0;
    int          k1 = 0;

    assign bus0.miso = bit0;
    assign bus1.miso = bit1;

    always @(negedge bus0.cs_n or negedge bus0.sclk) begin
        if (bus0.sclk) begin
            word0 = next_frame;
            k0    = 0;
        end else if (!bus0.cs_n && k0 < FB) begin
            bit0 = word0[FB-1-k0];
            k0++;
        end
    end

    always @(negedge bus1.cs_n or negedge bus1.sclk) begin
        if (bus1.sclk) begin
            word1 = next_frame;
            k1    = 0;
        end else if (!bus1.cs_n && k1 < FB) begin
            bit1 = word1[FB-1-k1];
            k1++;
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          e = 0;
    int          m_timer[2] = '{0, 0};
    int          m_start[2] = '{-1000, -1000};
    logic        m_ovr[2] = '{1'b0, 1'b0};
    logic [15:0] m_val[2] = '{16'h0, 16'h0};
    logic [15:0] frames[$] = '{16'h0FFC, 16'h0000, 16'hF557};

    function automatic logic [15:0] extract(logic [15:0] w);
        return (w >> (FB - LB - AB)) & 16'h03FF;
    endfunction

    task automatic chk(string tag, int i, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s dut%0d cyc %0d obs=%h exp=%h", tag, i, e, obs, exp);
        end
    endtask

    // Frame occupies cycles start+1 .. start+FL after its tick edge
    task automatic model_edge(int i, int per);
        logic tk;
        logic act;
        if (reset) begin
            m_timer[i] = 0;
            m_start[i] = -1000;
            m_ovr[i]   = 1'b0;
            m_val[i]   = '0;
        end else begin
            tk  = en && (m_timer[i] == 0);
            act = (e >= m_start[i] + 1) && (e <= m_start[i] + FL);
            m_ovr[i] = tk && act;
            if (tk && !act) m_start[i] = e;
            m_timer[i] = en ? (m_timer[i] + 1) % per : 0;
        end
    endtask

    task automatic check_dut(int i, logic [15:0] w, logic cs_n, logic sclk,
                             logic busy, logic vv, logic [15:0] vo, logic ov);
        int   d;
        logic low;
        logic valid;
        logic sc;
        d     = e - m_start[i] - 1;
        low   = (d >= 0) && (d < FL - 1);
        valid = (d == FL - 1);
        if (valid) m_val[i] = extract(w);
        sc = 1'b1;
        if (d >= CD && d < CD + 2 * CD * FB)
            sc = ((d - CD) % (2 * CD)) >= CD;
        chk("cs_n", i, 16'(cs_n), 16'(!low));
        chk("busy", i, 16'(busy), 16'(low));
        chk("sclk", i, 16'(sclk), 16'(sc));
        chk("val_valid", i, 16'(vv), 16'(valid));
        chk("val_out", i, vo, m_val[i]);
        chk("overrun", i, 16'(ov), 16'(m_ovr[i]));
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge(0, 200);
            model_edge(1, 100);
            e++;
            #1;
            check_dut(0, word0, bus0.cs_n, bus0.sclk, bus0.busy,
                      bus0.val_valid, bus0.val_out, bus0.overrun);
            check_dut(1, word1, bus1.cs_n, bus1.sclk, bus1.busy,
                      bus1.val_valid, bus1.val_out, bus1.overrun);
            if (e == m_start[0] + FL)
                next_frame = (frames.size() != 0) ? frames.pop_front()
                                                  : 16'($urandom);
        end
    endtask

    task automatic wait_offset(int off);
        int n;
        n = 0;
        while (e != m_start[0] + off && n < 500) begin
            run(1);
            n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        run(3);

        // directed frames 0x2A5, 0x3FF, 0x000, 0x155 (lead/trail ones)
        reset = 1'b0;
        en    = 1'b1;
        run(820);

        // reset mid-shift
        wait_offset(60);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(300);

        // en dropped mid-frame, later raised again
        wait_offset(50);
        en = 1'b0;
        run(300);
        en = 1'b1;
        run(150);

        // random en activity with random frame words
        for (int j = 0; j < 8; j++) begin
            en = ($urandom_range(0, 3) != 0);
            run($urandom_range(20, 300));
        end
        en = 1'b1;
        run(450);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
